eeprom_arbiter: RTL



---
 rtl/eeprom_pkg.sv | 15 +
 rtl/eeprom_rr_pick.sv | 36 +++
 rtl/eeprom_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/eeprom_pkg.sv
// Shared types and widths for the EEPROM arbiter and its round-robin picker.
package eeprom_pkg;

  localparam int EE_ADDR_W = 11;
  localparam int EE_DATA_W = 8;

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    WAIT,
    GAP,
    RESPOND
  } state_t;

endpackage

// File: rtl/eeprom_rr_pick.sv
// Combinational round-robin picker: searches upward from last_i+1 (mod NUM_REQ)
// and returns a one-hot grant for the first set request bit.
module eeprom_rr_pick
  import eeprom_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               any_o
);

  logic [IDX_W:0] cand;
  logic           found;

  // Walk the candidates in priority order and keep only the first hit.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    grant_o = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_i} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && valid_i[cand[IDX_W-1:0]]) begin
        grant_o[cand[IDX_W-1:0]] = 1'b1;
        found                    = 1'b1;
      end
    end
  end

  assign any_o = |valid_i;

endmodule

// File: rtl/eeprom_arbiter.sv
// Shares one EEPROM byte-read engine between NUM_REQ requesters: boot hold-off,
// round-robin grant, one outstanding read, per-read timeout with bounded retries.
module eeprom_arbiter
  import eeprom_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int BOOT_DELAY     = 1_600_000,
  parameter int TIMEOUT_CYCLES = 32_000,
  parameter int MAX_RETRY      = 2,
  parameter int GAP_CYCLES     = 160
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*EE_ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [EE_DATA_W-1:0]           rsp_data,
  output logic                           rsp_timeout,
  output logic [EE_ADDR_W-1:0]           ee_addr,
  output logic                           ee_read,
  input  logic [EE_DATA_W-1:0]           ee_data,
  input  logic                           ee_data_ready,
  output logic                           busy
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BOOT_W = $clog2(BOOT_DELAY) + 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;
  localparam int RTRY_W = $clog2(MAX_RETRY) + 1;

  state_t                 state_q;
  logic [BOOT_W-1:0]      boot_cnt_q;
  logic [TMO_W-1:0]       timer_q;
  logic [GAP_W-1:0]       gap_cnt_q;
  logic [RTRY_W-1:0]      retry_q;
  logic [IDX_W-1:0]       last_q;
  logic [IDX_W-1:0]       win_q;
  logic [NUM_REQ-1:0]     req_ready_q;
  logic [NUM_REQ-1:0]     rsp_valid_q;
  logic [EE_DATA_W-1:0]   rsp_data_q;
  logic                   rsp_timeout_q;
  logic [EE_ADDR_W-1:0]   ee_addr_q;
  logic                   ee_read_q;
  logic                   busy_q;

  logic [NUM_REQ-1:0]     grant_d;
  logic                   any_d;
  logic [IDX_W-1:0]       win_d;
  logic [EE_ADDR_W-1:0]   win_addr_d;

  eeprom_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid_i (req_valid),
    .last_i  (last_q),
    .grant_o (grant_d),
    .any_o   (any_d)
  );

  // Convert the one-hot grant into a winner index and select its address.
  always_comb begin
    win_d      = '0;
    win_addr_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_d[i]) begin
        win_d      = IDX_W'(i);
        win_addr_d = req_addr[i*EE_ADDR_W +: EE_ADDR_W];
      end
    end
  end

  // Arbiter FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      boot_cnt_q    <= '0;
      timer_q       <= '0;
      gap_cnt_q     <= '0;
      retry_q       <= '0;
      last_q        <= IDX_W'(NUM_REQ - 1);
      win_q         <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      ee_addr_q     <= '0;
      ee_read_q     <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      // NOTE: non-blocking defaults drop every pulse output; a later assignment in
      // the same cycle overrides the default, so each pulse lasts one cycle.
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      ee_read_q     <= 1'b0;
      unique case (state_q)
        BOOT: begin
          if (boot_cnt_q == BOOT_W'(BOOT_DELAY - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            boot_cnt_q <= boot_cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (any_d) begin
            win_q       <= win_d;
            ee_addr_q   <= win_addr_d;
            retry_q     <= '0;
            timer_q     <= '0;
            req_ready_q <= grant_d;
            ee_read_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          // Data beats the timeout, even in the terminal cycle. The timer counts
          // cycles after the strobe, so the strobe cycle itself is not counted.
          if (ee_data_ready) begin
            rsp_valid_q[win_q] <= 1'b1;
            rsp_data_q         <= ee_data;
            state_q            <= RESPOND;
          end else if (!ee_read_q) begin
            if (timer_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
              if (retry_q < RTRY_W'(MAX_RETRY)) begin
                retry_q   <= retry_q + 1'b1;
                gap_cnt_q <= '0;
                state_q   <= GAP;
              end else begin
                rsp_valid_q[win_q] <= 1'b1;
                rsp_timeout_q      <= 1'b1;
                state_q            <= RESPOND;
              end
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
            ee_read_q <= 1'b1;
            timer_q   <= '0;
            state_q   <= WAIT;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        RESPOND: begin
          last_q    <= win_q;
          ee_addr_q <= '0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign ee_addr     = ee_addr_q;
  assign ee_read     = ee_read_q;
  assign busy        = busy_q;

endmodule
